// File: rtl/md_unit.sv
// HI/LO multiply-divide unit with a fixed-latency busy window.
// Results are computed at issue and retired into hi/lo at completion.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        req_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   phi_q, phi_d;
  logic [31:0]   plo_q, plo_d;
  logic          pwr_q, pwr_d;

  logic op_mult, op_multu, op_div;
  logic op_divu, op_mthi, op_mtlo;

  logic signed [63:0] s_a, s_b, s_prod;
  logic        [63:0] u_prod;
  logic        [31:0] sdiv, udiv;
  logic        [31:0] sq, sr, uq, ur;
  logic               dz, ovf;

  assign op_mult  = (md_op == 3'd0);
  assign op_multu = (md_op == 3'd1);
  assign op_div   = (md_op == 3'd2);
  assign op_divu  = (md_op == 3'd3);
  assign op_mthi  = (md_op == 3'd4);
  assign op_mtlo  = (md_op == 3'd5);

  // Arithmetic; divisors are made safe so 0 and
  // INT_MIN/-1 never reach the dividers.
  assign s_a    = {{32{a[31]}}, a};
  assign s_b    = {{32{b[31]}}, b};
  assign s_prod = s_a * s_b;
  assign u_prod = {32'b0, a} * {32'b0, b};
  assign dz     = (b == 32'd0);
  assign ovf    = (a == 32'h8000_0000) &&
                  (b == 32'hFFFF_FFFF);
  assign sdiv   = (dz || ovf) ? 32'd1 : b;
  assign udiv   = dz ? 32'd1 : b;
  assign sq     = $signed(a) / $signed(sdiv);
  assign sr     = $signed(a) % $signed(sdiv);
  assign uq     = a / udiv;
  assign ur     = a % udiv;

  // Next-state, counter, pending and HI/LO update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    pwr_d   = pwr_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          unique case (1'b1)
            op_mult: begin
              phi_d   = s_prod[63:32];
              plo_d   = s_prod[31:0];
              pwr_d   = 1'b1;
              cnt_d   = CW'(MULT_CYCLES);
              busy_d  = 1'b1;
              state_d = RUN;
            end
            op_multu: begin
              phi_d   = u_prod[63:32];
              plo_d   = u_prod[31:0];
              pwr_d   = 1'b1;
              cnt_d   = CW'(MULT_CYCLES);
              busy_d  = 1'b1;
              state_d = RUN;
            end
            op_div: begin
              phi_d   = sr;
              plo_d   = sq;
              pwr_d   = !dz;
              cnt_d   = CW'(DIV_CYCLES);
              busy_d  = 1'b1;
              state_d = RUN;
            end
            op_divu: begin
              phi_d   = ur;
              plo_d   = uq;
              pwr_d   = !dz;
              cnt_d   = CW'(DIV_CYCLES);
              busy_d  = 1'b1;
              state_d = RUN;
            end
            op_mthi: hi_d = a;
            op_mtlo: lo_d = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          if (pwr_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      pwr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      pwr_q   <= pwr_d;
    end
  end

  assign busy     = busy_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign md_stall = req_md & (start | busy_q);

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy duration of mult/multu in cycles (>=1).
REQ-002 Parameter DIV_CYCLES, default 10, busy duration of div/divu in cycles (>=1).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  E-stage md instruction valid this cycle.
REQ-006 md_op  input  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo; 6/7 = no-op.
REQ-007 a  input  32  rs operand, already forwarded.
REQ-008 b  input  32  rt operand, already forwarded.
REQ-009 req_md  input  1  D-stage instruction uses HI/LO or the md unit (mult/div/mfhi/mflo/mthi/mtlo).
REQ-010 busy  output  1  a multiply or divide is in progress.
REQ-011 md_stall  output  1  stall request to the hazard unit.
REQ-012 hi  output  32  architectural HI register.
REQ-013 lo  output  32  architectural LO register.

Function
REQ-014 The block SHALL have two states: IDLE and RUN.
REQ-015 IDLE, start=1, md_op in 0..3: latch the result into pending HI/LO; load the cycle counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
REQ-016 busy SHALL be 1 exactly in RUN: N consecutive cycles starting the cycle after the start edge, where N is the loaded count.
REQ-017 RUN: the counter SHALL decrement each cycle. At the edge where it reaches 0, pending values SHALL be written to hi/lo and the state SHALL return to IDLE. busy is 0 in the following cycle.
REQ-018 hi/lo SHALL NOT change during RUN before completion.
REQ-019 mult: {hi,lo} SHALL equal the 64-bit signed product. multu: the 64-bit unsigned product.
REQ-020 div: lo SHALL equal the signed quotient truncated toward zero, and hi the remainder with the sign of a. divu: unsigned quotient and remainder.
REQ-021 div with a=0x80000000, b=0xFFFFFFFF SHALL yield lo=0x80000000, hi=0.
REQ-022 div/divu with b=0: the full busy period SHALL still run; hi/lo SHALL remain unchanged at completion.
REQ-023 mthi/mtlo with start=1 in IDLE SHALL write a into hi/lo at that edge, with no busy.
REQ-024 start=1 in RUN, any md_op: SHALL be ignored. No state, counter or pending change.
REQ-025 md_op 6/7 with start=1 SHALL be a no-op.
REQ-026 md_stall SHALL equal req_md & (start | busy), combinational and same cycle.
REQ-027 hi, lo and busy SHALL be register outputs. No combinational path from a/b to any output.

Reset
REQ-028 reset=0 SHALL immediately force state=IDLE, counter=0, busy=0, hi=0, lo=0, and clear pending values.
REQ-029 Reset asserted during RUN SHALL abort the operation; the pending result SHALL never reach hi/lo.
REQ-030 md_stall SHALL read 0 while in reset if req_md=0 and start=0.
REQ-031 After reset deasserts, the first start SHALL be accepted on the next rising edge.

Verification
REQ-032 mult a=3, b=0xFFFFFFFE -> busy=1 for 5 cycles. Then hi=0xFFFFFFFF, lo=0xFFFFFFFA. hi/lo hold their old values until then.
REQ-033 divu a=7, b=2 -> busy 10 cycles, then lo=3, hi=1. div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-034 req_md=1 during all RUN cycles and in the start cycle -> md_stall=1 in each. Cycle after completion -> md_stall=0.
REQ-035 Second start (mtlo a=0x1234) issued mid-RUN -> ignored. Final lo is the mult/div result, not 0x1234.
REQ-036 reset pulsed low at RUN cycle 3 of a mult -> busy=0, hi=lo=0 immediately. Both remain 0 after the original completion time.
REQ-037 divu b=0 with hi=0xA, lo=0xB preloaded via mthi/mtlo -> busy 10 cycles, then hi=0xA, lo=0xB.
